// File: rtl/lcd_text_engine.sv
// lcd_text_engine: HD44780-style 8-bit LCD controller that powers up the
// panel, then writes one selectable message per request to line 0 or 1.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_req, i_cmd        command handshake (00 write, 01 clear, 10 re-init, 11 nop)
//   i_msg_id, i_line    message and target line for a write command
//   o_char_msg/idx      address presented to the external character table
//   i_char              character returned for that address (combinational)
//   o_ready             engine idle, next request may be accepted
//   LCD_*               LCD data bus and control lines
module lcd_text_engine #(
    parameter int CLK_HZ      = 12_000_000,
    parameter int NUM_MSG     = 8,
    parameter int LINE_LEN    = 16,
    parameter int EN_HIGH_CYC = 6,
    localparam int MW = $clog2(NUM_MSG),
    localparam int IW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req,
    input  logic [1:0]    i_cmd,
    input  logic [MW-1:0] i_msg_id,
    input  logic          i_line,
    output logic [MW-1:0] o_char_msg,
    output logic [IW-1:0] o_char_idx,
    input  logic [7:0]    i_char,
    output logic          o_ready,
    output logic [7:0]    LCD_DATA,
    output logic          LCD_EN,
    output logic          LCD_RW,
    output logic          LCD_RS,
    output logic          LCD_ON,
    output logic          LCD_BLON
);

    function automatic longint wait_cyc(input longint us);
        return (longint'(CLK_HZ) * us + 64'd999_999) / 64'd1_000_000;
    endfunction

    localparam longint W_PWR  = wait_cyc(15000);
    localparam longint W_4100 = wait_cyc(4100);
    localparam longint W_100  = wait_cyc(100);
    localparam longint W_1530 = wait_cyc(1530);
    localparam longint W_43   = wait_cyc(43);
    localparam longint W_EN   = longint'(EN_HIGH_CYC);
    localparam longint W_MAX  = (W_PWR > W_EN) ? W_PWR : W_EN;
    localparam int     TW     = $clog2(W_MAX + 1);

    typedef logic [TW-1:0] tmr_t;

    // Timer compare values are "last cycle" values (count - 1).
    localparam tmr_t T_PWR  = tmr_t'(W_PWR - 1);
    localparam tmr_t T_4100 = tmr_t'(W_4100 - 1);
    localparam tmr_t T_100  = tmr_t'(W_100 - 1);
    localparam tmr_t T_1530 = tmr_t'(W_1530 - 1);
    localparam tmr_t T_43   = tmr_t'(W_43 - 1);
    localparam tmr_t T_EN   = tmr_t'(W_EN - 1);

    localparam logic [IW-1:0] IDX_LAST = IW'(LINE_LEN - 1);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_SEQ,
        IDLE,
        SET_ADDR,
        WR_CHAR,
        PAD,
        CLR
    } state_t;

    // Transfer sub-phases. PH_LOOK is the character fetch cycle in
    // WR_CHAR, and a one-cycle busy gap in IDLE for the reserved command.
    typedef enum logic [2:0] {
        PH_NONE,
        PH_LOOK,
        PH_SETUP,
        PH_EN,
        PH_WAIT
    } phase_t;

    state_t        state, state_d;
    phase_t        phase, phase_d;
    tmr_t          timer, timer_d;
    tmr_t          lim;
    logic          tick;
    logic [2:0]    step, step_d;
    logic [IW-1:0] idx, idx_d;
    logic [MW-1:0] msg, msg_d;
    logic [7:0]    data, data_d;
    logic          rs, rs_d;
    logic          en, en_d;

    function automatic logic [7:0] init_cmd(input logic [2:0] s);
        unique case (s)
            3'd4:    return 8'h0C;
            3'd5:    return 8'h01;
            3'd6:    return 8'h06;
            default: return 8'h38;
        endcase
    endfunction

    function automatic tmr_t init_wait(input logic [2:0] s);
        unique case (s)
            3'd0:    return T_4100;
            3'd1:    return T_100;
            3'd5:    return T_1530;
            default: return T_43;
        endcase
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= PWR_WAIT;
            phase <= PH_NONE;
            timer <= '0;
            step  <= '0;
            idx   <= '0;
            msg   <= '0;
            data  <= '0;
            rs    <= 1'b0;
            en    <= 1'b0;
        end else begin
            state <= state_d;
            phase <= phase_d;
            timer <= timer_d;
            step  <= step_d;
            idx   <= idx_d;
            msg   <= msg_d;
            data  <= data_d;
            rs    <= rs_d;
            en    <= en_d;
        end
    end

    // Terminal count for whatever the timer is currently measuring.
    always_comb begin
        lim = T_43;
        if (state == PWR_WAIT)
            lim = T_PWR;
        else if (phase == PH_EN)
            lim = T_EN;
        else if (state == INIT_SEQ)
            lim = init_wait(step);
        else if (state == CLR)
            lim = T_1530;
    end

    assign tick    = (timer == lim);
    assign o_ready = (state == IDLE) && (phase == PH_NONE);

    always_comb begin
        state_d = state;
        phase_d = phase;
        timer_d = '0;
        step_d  = step;
        idx_d   = idx;
        msg_d   = msg;
        data_d  = data;
        rs_d    = rs;
        en_d    = 1'b0;
        unique case (state)
            PWR_WAIT: begin
                if (tick) begin
                    state_d = INIT_SEQ;
                    step_d  = '0;
                    data_d  = init_cmd(3'd0);
                    rs_d    = 1'b0;
                    phase_d = PH_SETUP;
                end else begin
                    timer_d = timer + tmr_t'(1);
                end
            end
            IDLE: begin
                phase_d = PH_NONE;
                if (o_ready && i_req) begin
                    msg_d = i_msg_id;
                    idx_d = '0;
                    unique case (i_cmd)
                        2'b00: begin
                            state_d = SET_ADDR;
                            data_d  = i_line ? 8'hC0 : 8'h80;
                            rs_d    = 1'b0;
                            phase_d = PH_SETUP;
                        end
                        2'b01: begin
                            state_d = CLR;
                            data_d  = 8'h01;
                            rs_d    = 1'b0;
                            phase_d = PH_SETUP;
                        end
                        2'b10: begin
                            state_d = PWR_WAIT;
                        end
                        default: begin
                            phase_d = PH_LOOK;
                        end
                    endcase
                end
            end
            default: begin
                unique case (phase)
                    PH_SETUP: begin
                        phase_d = PH_EN;
                        en_d    = 1'b1;
                    end
                    PH_EN: begin
                        if (tick) begin
                            phase_d = PH_WAIT;
                        end else begin
                            en_d    = 1'b1;
                            timer_d = timer + tmr_t'(1);
                        end
                    end
                    PH_WAIT: begin
                        if (!tick) begin
                            timer_d = timer + tmr_t'(1);
                        end else begin
                            unique case (state)
                                INIT_SEQ: begin
                                    if (step == 3'd6) begin
                                        state_d = IDLE;
                                        phase_d = PH_NONE;
                                    end else begin
                                        step_d  = step + 3'd1;
                                        data_d  = init_cmd(step + 3'd1);
                                        phase_d = PH_SETUP;
                                    end
                                end
                                SET_ADDR: begin
                                    state_d = WR_CHAR;
                                    idx_d   = '0;
                                    phase_d = PH_LOOK;
                                end
                                WR_CHAR, PAD: begin
                                    if (idx == IDX_LAST) begin
                                        state_d = IDLE;
                                        phase_d = PH_NONE;
                                    end else if (state == WR_CHAR) begin
                                        idx_d   = idx + IW'(1);
                                        phase_d = PH_LOOK;
                                    end else begin
                                        idx_d   = idx + IW'(1);
                                        data_d  = 8'h20;
                                        rs_d    = 1'b1;
                                        phase_d = PH_SETUP;
                                    end
                                end
                                default: begin
                                    state_d = IDLE;
                                    phase_d = PH_NONE;
                                end
                            endcase
                        end
                    end
                    PH_LOOK: begin
                        // NUL ends the text; the rest of the line is blanked.
                        rs_d    = 1'b1;
                        phase_d = PH_SETUP;
                        if (i_char == 8'h00) begin
                            state_d = PAD;
                            data_d  = 8'h20;
                        end else begin
                            data_d  = i_char;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        phase_d = PH_NONE;
                    end
                endcase
            end
        endcase
    end

    assign o_char_msg = msg;
    assign o_char_idx = idx;
    assign LCD_DATA   = data;
    assign LCD_RS     = rs;
    assign LCD_EN     = en;
    assign LCD_RW     = 1'b0;
    assign LCD_ON     = 1'b1;
    assign LCD_BLON   = 1'b0;

endmodule

// File: tb/tb_lcd_text_engine.sv
// tb_lcd_text_engine: randomized bench with a transfer-level reference
// model of the LCD command stream and timing rules.
module tb_lcd_text_engine;

    localparam int CLK_HZ = 1_000_000;
    localparam int NMSG   = 8;
    localparam int LLEN   = 16;
    localparam int ENH    = 2;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         wt;
        int         pre;
    } xfer_t;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_req = 1'b0;
    logic [1:0] i_cmd = 2'b00;
    logic [2:0] i_msg_id = 3'd0;
    logic       i_line = 1'b0;
    logic [2:0] o_char_msg;
    logic [3:0] o_char_idx;
    logic [7:0] i_char;
    logic       o_ready;
    logic [7:0] lcd_data;
    logic       lcd_en, lcd_rw, lcd_rs, lcd_on, lcd_blon;

    logic [7:0] rom [NMSG][LLEN];
    assign i_char = rom[o_char_msg][o_char_idx];

    lcd_text_engine #(
        .CLK_HZ(CLK_HZ), .NUM_MSG(NMSG),
        .LINE_LEN(LLEN), .EN_HIGH_CYC(ENH)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_cmd(i_cmd),
        .i_msg_id(i_msg_id), .i_line(i_line),
        .o_char_msg(o_char_msg), .o_char_idx(o_char_idx),
        .i_char(i_char), .o_ready(o_ready),
        .LCD_DATA(lcd_data), .LCD_EN(lcd_en), .LCD_RW(lcd_rw),
        .LCD_RS(lcd_rs), .LCD_ON(lcd_on), .LCD_BLON(lcd_blon)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    xfer_t exp_q[$];
    xfer_t mq[$];

    task automatic check(input bit ok, input string name,
                         input int act, input int req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, req, req);
        end
    endtask

    // Expected LCD stream for one write command, straight from the rules.
    task automatic build_msg(input int m, input bit ln);
        bit ended = 0;
        mq.delete();
        mq.push_back('{1'b0, ln ? 8'hC0 : 8'h80, 43, 0});
        for (int k = 0; k < LLEN; k++) begin
            if (rom[m][k] == 8'h00) ended = 1;
            mq.push_back('{1'b1, ended ? 8'h20 : rom[m][k], 43, 0});
        end
    endtask

    task automatic push_init();
        exp_q.push_back('{1'b0, 8'h38, 4100, 15000});
        exp_q.push_back('{1'b0, 8'h38, 100, 0});
        exp_q.push_back('{1'b0, 8'h38, 43, 0});
        exp_q.push_back('{1'b0, 8'h38, 43, 0});
        exp_q.push_back('{1'b0, 8'h0C, 43, 0});
        exp_q.push_back('{1'b0, 8'h01, 1530, 0});
        exp_q.push_back('{1'b0, 8'h06, 43, 0});
    endtask

    // Monitor / compare process, sampling 1 time unit after each edge.
    int cyc = 0;
    int rise_c = 0, fall_c = 0, rel_c = 0;
    int cur_wt = 0, last_wt = 0;
    bit en_p = 0, have_prev = 0, after_rst = 1, rst_p = 1;
    logic [7:0] d_p = 8'h00, d_r = 8'h00;
    logic rs_p = 1'b0, rs_r = 1'b0;

    always @(posedge clk) begin
        xfer_t it;
        #1;
        cyc++;
        if (i_rst) begin
            en_p = 0;
            have_prev = 0;
            after_rst = 1;
        end else begin
            if (rst_p) rel_c = cyc;
            if (lcd_en && !en_p) begin
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_xfer", lcd_data, 0);
                    it = '{lcd_rs, lcd_data, 43, 0};
                end else begin
                    it = exp_q.pop_front();
                end
                check(lcd_data == it.data, "xfer_data", lcd_data, it.data);
                check(lcd_rs == it.rs, "xfer_rs", lcd_rs, it.rs);
                check(lcd_data == d_p && lcd_rs == rs_p, "setup_hold",
                      d_p, lcd_data);
                if (have_prev && !after_rst)
                    check(cyc - fall_c >= last_wt + 1, "rise_gap",
                          cyc - fall_c, last_wt + 1);
                if (it.pre > 0)
                    check(cyc - (after_rst ? rel_c : fall_c) >= it.pre,
                          "power_wait",
                          cyc - (after_rst ? rel_c : fall_c), it.pre);
                after_rst = 0;
                rise_c = cyc;
                cur_wt = it.wt;
                d_r = lcd_data;
                rs_r = lcd_rs;
            end else if (lcd_en && en_p) begin
                if (lcd_data != d_r || lcd_rs != rs_r)
                    check(0, "data_during_en", lcd_data, d_r);
            end else if (!lcd_en && en_p) begin
                check(cyc - rise_c == ENH, "en_width", cyc - rise_c, ENH);
                fall_c = cyc;
                last_wt = cur_wt;
                have_prev = 1;
            end else if (have_prev && (lcd_data != d_p || lcd_rs != rs_p)) begin
                check(cyc - fall_c >= last_wt, "hold_after_fall",
                      cyc - fall_c, last_wt);
            end
            en_p = lcd_en;
        end
        rst_p = i_rst;
        d_p = lcd_data;
        rs_p = lcd_rs;
    end

    task automatic wait_ready(input int bound, input bit noise);
        bit got = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            i_req = 1'b0;
            if (o_ready) begin
                got = 1;
                break;
            end
            if (noise && $urandom_range(0, 5) == 0) begin
                i_req = 1'b1;
                i_cmd = 2'($urandom_range(0, 3));
                i_msg_id = 3'($urandom_range(0, NMSG - 1));
                i_line = 1'($urandom_range(0, 1));
            end
        end
        check(got, "ready_timeout", got, 1);
        if (got)
            check(exp_q.size() == 0, "pending_xfers", exp_q.size(), 0);
    endtask

    // Called on a negedge where o_ready is 1.
    task automatic issue(input logic [1:0] c, input int m, input bit ln);
        i_req = 1'b1;
        i_cmd = c;
        i_msg_id = 3'(m);
        i_line = ln;
        if (c == 2'b00) begin
            build_msg(m, ln);
            foreach (mq[k]) exp_q.push_back(mq[k]);
        end else if (c == 2'b01) begin
            exp_q.push_back('{1'b0, 8'h01, 1530, 0});
        end else if (c == 2'b10) begin
            push_init();
        end
        @(negedge clk);
        i_req = 1'b0;
        check(o_ready == 1'b0, "ready_drop", o_ready, 0);
    endtask

    task automatic rand_rom(input int m);
        int len = $urandom_range(0, LLEN);
        for (int k = 0; k < LLEN; k++)
            rom[m][k] = (k == len) ? 8'h00 : 8'($urandom_range(8'h21, 8'h7E));
    endtask

    task automatic check_reset_outputs(input string tag);
        check(lcd_en == 1'b0, {tag, "_en"}, lcd_en, 0);
        check(lcd_rs == 1'b0, {tag, "_rs"}, lcd_rs, 0);
        check(lcd_data == 8'h00, {tag, "_data"}, lcd_data, 0);
        check(o_ready == 1'b0, {tag, "_ready"}, o_ready, 0);
        check(o_char_idx == 4'd0, {tag, "_idx"}, o_char_idx, 0);
        check(o_char_msg == 3'd0, {tag, "_msg"}, o_char_msg, 0);
    endtask

    initial begin
        string play;
        int r;
        bit seen;
        play = "PLAY";
        for (int m = 0; m < NMSG; m++) rand_rom(m);
        for (int k = 0; k < LLEN; k++) begin
            rom[0][k] = (k < 4) ? play[k] : 8'($urandom_range(8'h21, 8'h7E));
            rom[1][k] = 8'h41 + 8'(k);
        end
        rom[0][4] = 8'h00;

        // Pin the model with hand-derived literals.
        build_msg(0, 1);
        check(mq.size() == 17, "model_play_len", mq.size(), 17);
        check(mq[0].data == 8'hC0, "model_play_addr", mq[0].data, 8'hC0);
        check(mq[4].data == 8'h59, "model_play_y", mq[4].data, 8'h59);
        check(mq[5].data == 8'h20, "model_play_pad", mq[5].data, 8'h20);
        check(mq[16].data == 8'h20, "model_play_last", mq[16].data, 8'h20);
        build_msg(1, 0);
        check(mq[0].data == 8'h80, "model_full_addr", mq[0].data, 8'h80);
        check(mq[16].data == 8'h50, "model_full_last", mq[16].data, 8'h50);

        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        check(lcd_rw == 1'b0, "rw_tied", lcd_rw, 0);
        check(lcd_on == 1'b1, "on_tied", lcd_on, 1);
        check(lcd_blon == 1'b0, "blon_tied", lcd_blon, 0);

        push_init();
        i_rst = 1'b0;
        wait_ready(25000, 1);

        // "PLAY" on the bottom line, with ignored requests while busy.
        issue(2'b00, 0, 1);
        wait_ready(2000, 1);

        // Full-length message: no padding.
        issue(2'b00, 1, 0);
        wait_ready(2000, 1);

        // Clear, then confirm the long post-clear wait.
        issue(2'b01, 0, 0);
        wait_ready(3000, 1);
        check(cyc - fall_c >= 1530, "clr_wait", cyc - fall_c, 1530);

        // Reserved command: brief busy, no LCD activity.
        issue(2'b11, 0, 0);
        wait_ready(10, 0);

        for (int n = 0; n < 10; n++) begin
            rand_rom($urandom_range(2, NMSG - 1));
            r = $urandom_range(0, 9);
            issue(r < 6 ? 2'b00 : (r < 8 ? 2'b01 : 2'b11),
                  $urandom_range(0, NMSG - 1), 1'($urandom_range(0, 1)));
            wait_ready(3000, 1);
        end

        // Re-initialise on command.
        issue(2'b10, 0, 0);
        wait_ready(25000, 1);

        // Reset while EN is high during a character write.
        issue(2'b00, 1, 1);
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (lcd_en && lcd_rs) begin
                seen = 1;
                break;
            end
        end
        check(seen, "wrchar_en_seen", seen, 1);
        i_rst = 1'b1;
        #1;
        check(lcd_en == 1'b0, "async_en_drop", lcd_en, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");
        push_init();
        i_rst = 1'b0;
        wait_ready(25000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_text_engine.md
LCD_TEXT_ENGINE -- requirements
Module: lcd_text_engine

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter NUM_MSG, default 8, number of selectable messages (power of 2, >=2).
REQ-003 SHALL have parameter LINE_LEN, default 16, characters per LCD line (1..40).
REQ-004 SHALL have parameter EN_HIGH_CYC, default 6, LCD_EN high width in clocks (>=1).
REQ-005 SHALL have one clock and asynchronous active-high reset, ports i_clk and i_rst, listed first.
REQ-006 i_clk  input  1  system clock; all state updates on rising edge.
REQ-007 i_rst  input  1  asynchronous, active-high reset.
REQ-008 i_req  input  1  command request, sampled when o_ready=1.
REQ-009 i_cmd  input  2  00=write message, 01=clear display, 10=re-initialise, 11=reserved (accepted, no LCD activity).
REQ-010 i_msg_id  input  $clog2(NUM_MSG)  message selected for cmd 00.
REQ-011 i_line  input  1  target line for cmd 00 (0=top DDRAM 0x00, 1=bottom 0x40).
REQ-012 o_char_msg  output  $clog2(NUM_MSG)  message index for external character lookup.
REQ-013 o_char_idx  output  $clog2(LINE_LEN)  character index for external lookup.
REQ-014 i_char  input  8  character code for (o_char_msg, o_char_idx), valid combinationally the same cycle.
REQ-015 o_ready  output  1  engine idle, able to accept i_req.
REQ-016 LCD_DATA  output  8  LCD data bus (write only).
REQ-017 LCD_EN / LCD_RW / LCD_RS / LCD_ON / LCD_BLON  output  1 each  LCD strobe, read/write (tied 0), register select, power (tied 1), backlight (tied 0).

Function
REQ-018 Wait counts SHALL be ceil(CLK_HZ*t/1e6) for t = 15000, 4100, 100, 1530, 43 us; counter width derived from the largest count.
REQ-019 Every LCD transfer SHALL: drive RS/DATA 1 cycle with EN=0, raise EN for EN_HIGH_CYC cycles, lower EN, hold RS/DATA until the post-command wait completes; the wait starts on EN fall.
REQ-020 States SHALL be PWR_WAIT, INIT_SEQ, IDLE, SET_ADDR, WR_CHAR, PAD, CLR.
REQ-021 PWR_WAIT SHALL hold EN=0 for the 15 ms count, then enter INIT_SEQ.
REQ-022 INIT_SEQ SHALL issue RS=0 commands, in order with waits: 0x38/4.1ms, 0x38/100us, 0x38/43us, 0x38/43us, 0x0C/43us, 0x01/1.53ms, 0x06/43us; then IDLE.
REQ-023 o_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with i_req=1 and o_ready=1, capturing i_cmd, i_msg_id and i_line; o_ready drops the next cycle.
REQ-024 i_req while o_ready=0 SHALL be ignored (no queuing).
REQ-025 cmd 00: SET_ADDR SHALL send RS=0 0x80|(line?0x40:0x00) with 43us wait, then WR_CHAR.
REQ-026 WR_CHAR SHALL write i_char with RS=1 and 43us wait per character, o_char_idx from 0 upward, o_char_msg = captured id.
REQ-027 i_char==0x00 SHALL terminate the message: the NUL is not written and PAD begins at that index.
REQ-028 PAD SHALL write 0x20 (RS=1, 43us each) up to index LINE_LEN-1 so stale text is overwritten; a message of exactly LINE_LEN non-NUL chars skips PAD; then IDLE.
REQ-029 cmd 01: CLR SHALL send RS=0 0x01 with 1.53ms wait, then IDLE.
REQ-030 cmd 10 SHALL enter PWR_WAIT and repeat the full initialisation.
REQ-031 Character index SHALL not wrap; exactly LINE_LEN data writes occur per cmd 00.
REQ-032 LCD_RW SHALL be constant 0, LCD_ON constant 1, LCD_BLON constant 0.

Reset
REQ-033 While i_rst=1: state PWR_WAIT, timer 0, EN=0, RS=0, DATA=0x00, o_ready=0, o_char_idx=0, o_char_msg=0.
REQ-034 Reset asserted mid-transfer SHALL drop EN immediately (asynchronously) and, after release, restart the 15 ms power wait.

Verification (CLK_HZ=1_000_000, LINE_LEN=16, EN_HIGH_CYC=2)
REQ-035 Release reset -> first EN rise after >=15000 cycles; 7 EN pulses with DATA 38,38,38,38,0C,01,06; o_ready=1 afterwards.
REQ-036 cmd 00, line 1, message "PLAY"+NUL -> DATA 0xC0 (RS=0), then 'P','L','A','Y' then 12x 0x20 (RS=1); consecutive EN rises >=43+2+1 cycles apart.
REQ-037 cmd 00, 16 non-NUL chars -> exactly 17 EN pulses, no 0x20 padding.
REQ-038 cmd 01 -> single 0x01 pulse, o_ready returns >=1530 cycles after EN fall.
REQ-039 i_req pulses while busy -> no extra LCD transfers; cmd 11 -> o_ready low then high, no EN pulse.
REQ-040 Assert i_rst during EN high of a WR_CHAR -> EN=0 same cycle; after release, full init sequence repeats.
